// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Items shared by the non-restoring divider and its add/sub stage:
//   - the FSM state type (IDLE, ITER, FIX, DONE)
//   - the default operand width
//   - the iteration-counter width, derived from the operand width
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // The counter runs 0..w-1, so $clog2(w) bits are enough. The minimum of
  // one bit keeps degenerate widths legal.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/addsub_stage.sv
// -----------------------------------------------------------------------------
// addsub_stage
//   Combinational W-bit adder/subtractor. The divider owns one instance and
//   time-shares it between the iteration steps and the final correction step.
//   Ports:
//     a_i, b_i   operands (W bits)
//     op_i       1 = subtract (a - b), 0 = add (a + b)
//     result_o   W-bit result, modulo 2^W
// -----------------------------------------------------------------------------
module addsub_stage #(
  parameter int W = 5
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         op_i,
  output logic [W-1:0] result_o
);

  assign result_o = op_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/nonrestoring_divider.sv
// -----------------------------------------------------------------------------
// nonrestoring_divider
//   Multicycle integer divider that uses the non-restoring algorithm. Each
//   iteration selects add or subtract from the sign of the partial remainder.
//   No magnitude comparator is used. One add/sub stage is shared by all steps.
//
//   Optional feature: define DIV_SIGNED_EN to use two's-complement operands.
//   With it undefined, the divider is unsigned only and no sign logic is built.
//
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous, active-low reset
//     start        request; sampled only in IDLE or DONE
//     A, B         dividend and divisor; sampled with an accepted start
//     busy         high while iterating (ITER) and correcting (FIX)
//     done         one-cycle pulse; Q, R and div_by_zero are valid
//     Q, R         quotient and remainder; held until the next result
//     div_by_zero  B was zero on the last accepted start
//
//   Latency: for a start sampled at edge N, done is high during the cycle
//   after edge N+WIDTH+1, so it is sampled high at edge N+WIDTH+2.
//   For a zero divisor, done is high in the cycle right after the accept.
// -----------------------------------------------------------------------------
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam int              CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  div_state_e       state_q;
  logic [WIDTH:0]   p_q;      // partial remainder, one sign bit wider
  logic [WIDTH-1:0] qr_q;     // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] dr_q;     // divisor magnitude
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             dbz_q;

`ifdef DIV_SIGNED_EN
  logic             q_neg_q;  // operand signs differ
  logic             r_neg_q;  // dividend was negative
`endif

  // ---------------------------------------------------------------------------
  // Operand magnitudes taken at load
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

`ifdef DIV_SIGNED_EN
  // MIN negates to itself. Read as unsigned, that is its correct magnitude.
  assign a_mag = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_mag = B[WIDTH-1] ? (~B + 1'b1) : B;
`else
  assign a_mag = A;
  assign b_mag = B;
`endif

  // ---------------------------------------------------------------------------
  // Shared add/sub stage
  //   ITER: operand is {P,Qr} shifted left, with P's top bit dropped.
  //         Op comes from the sign of P before the shift.
  //   FIX : operand is P, and Op is forced to add.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] p_shift;
  logic [WIDTH:0] as_a;
  logic [WIDTH:0] as_b;
  logic           as_op;
  logic [WIDTH:0] as_sum;

  assign p_shift = {p_q[WIDTH-1:0], qr_q[WIDTH-1]};
  assign as_a    = (state_q == FIX) ? p_q : p_shift;
  assign as_b    = {1'b0, dr_q};
  assign as_op   = (state_q == ITER) ? ~p_q[WIDTH] : 1'b0;

  addsub_stage #(
    .W (WIDTH + 1)
  ) u_addsub (
    .a_i      (as_a),
    .b_i      (as_b),
    .op_i     (as_op),
    .result_o (as_sum)
  );

  // ---------------------------------------------------------------------------
  // Next values for the iteration and the final result
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] qr_iter_d;
  logic [WIDTH-1:0] r_mag_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] r_d;

  // A non-negative new remainder means this quotient bit is 1.
  assign qr_iter_d = {qr_q[WIDTH-2:0], ~as_sum[WIDTH]};

  // A negative final remainder has overshot by one divisor, so add it back.
  assign r_mag_d = p_q[WIDTH] ? as_sum[WIDTH-1:0] : p_q[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
  assign q_d = q_neg_q ? (~qr_q + 1'b1)    : qr_q;
  assign r_d = r_neg_q ? (~r_mag_d + 1'b1) : r_mag_d;
`else
  assign q_d = qr_q;
  assign r_d = r_mag_d;
`endif

  // ---------------------------------------------------------------------------
  // FSM, datapath registers and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: every register here is assigned with <=. All updates therefore
  // read the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      qr_q    <= '0;
      dr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            p_q   <= '0;
            qr_q  <= a_mag;
            dr_q  <= b_mag;
            cnt_q <= '0;
`ifdef DIV_SIGNED_EN
            q_neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
            r_neg_q <= A[WIDTH-1];
`endif
            if (B == '0) begin
              // Zero divisor: skip the iterations and report at once.
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              q_q     <= '1;
              r_q     <= A;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= ITER;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end

        ITER: begin
          p_q   <= as_sum;
          qr_q  <= qr_iter_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q <= FIX;
          end
        end

        FIX: begin
          p_q     <= p_q[WIDTH] ? as_sum : p_q;
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          q_q     <= q_d;
          r_q     <= r_d;
          dbz_q   <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;

endmodule
